coeff_sequencer: RTL and testbench

Producer side of the MAC's `signal_fifo`/`coeff_fifo` stream interface.

- Accepts one float32 sample and a function select.
- Streams that function's Taylor coefficients from an internal ROM in Horner order (highest order first), paired with the sample, then emits one NaN terminator beat.
- Sits between the activation-request front end and the `mac` block, replacing hand-driven coefficient streams.

---
 rtl/coeff_sequencer_if.sv | 29 ++
 rtl/coeff_sequencer.sv | 151 +++++++++++++++
 tb/tb_coeff_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_sequencer_if.sv
// Request and beat-stream bundle for coeff_sequencer.
// Master is the requester/consumer side; slave is the sequencer.
interface coeff_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] x_i;
    logic                  func_sel_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] signal_o;
    logic [DATA_WIDTH-1:0] coeff_o;
    logic                  last_o;
    logic                  done_o;
    logic                  busy_o;

    modport master (
        output in_valid_i, x_i, func_sel_i, out_ready_i,
        input  in_ready_o, out_valid_o, signal_o, coeff_o,
        input  last_o, done_o, busy_o
    );

    modport slave (
        input  in_valid_i, x_i, func_sel_i, out_ready_i,
        output in_ready_o, out_valid_o, signal_o, coeff_o,
        output last_o, done_o, busy_o
    );
endinterface

// File: rtl/coeff_sequencer.sv
// Streams Taylor coefficients (Horner order) paired with a sample,
// followed by a NaN terminator beat, into the MAC input FIFOs.
module coeff_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4,
    parameter int N_COEFF    = 10
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    coeff_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_TERM
    } state_t;

    localparam logic [DATA_WIDTH-1:0] NAN_W  = DATA_WIDTH'(32'h7F900000);
    localparam logic [ADDR_LINES-1:0] LAST_I = ADDR_LINES'(N_COEFF - 1);
    localparam logic [ADDR_LINES-1:0] ONE_I  = ADDR_LINES'(1);

    function automatic logic [DATA_WIDTH-1:0] rom(
        input logic                  f,
        input logic [ADDR_LINES-1:0] a
    );
        logic [31:0] v;
        v = '0;
        if (!f) begin
            case (int'(a))
                0: v = 32'h3493F27D;
                1: v = 32'h3638EF1D;
                2: v = 32'h37D00D01;
                3: v = 32'h39500D01;
                4: v = 32'h3AB60B61;
                5: v = 32'h3C088889;
                6: v = 32'h3D2AAAAB;
                7: v = 32'h3E2AAAAB;
                8: v = 32'h3F000000;
                9: v = 32'h3F800000;
                default: v = '0;
            endcase
        end else begin
            case (int'(a))
                0: v = 32'hA317A4DB;
                1: v = 32'hA74A963B;
                2: v = 32'hAB573F9F;
                3: v = 32'hAF309231;
                4: v = 32'hB2D7322B;
                5: v = 32'hB638EF1D;
                6: v = 32'hB9500D01;
                7: v = 32'hBC088889;
                8: v = 32'hBE2AAAAB;
                9: v = 32'hBF800000;
                default: v = '0;
            endcase
        end
        return DATA_WIDTH'(v);
    endfunction

    state_t                  r_state, w_state_nxt;
    logic                    r_func, w_func_nxt;
    logic [ADDR_LINES-1:0]   r_idx, w_idx_nxt;
    logic [DATA_WIDTH-1:0]   r_signal, w_signal_nxt;
    logic [DATA_WIDTH-1:0]   r_coeff, w_coeff_nxt;
    logic                    r_last, w_last_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_fire_in;
    logic                    w_fire_out;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat data is registered one step ahead so outputs never see out_ready_i.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_func   <= 1'b0;
            r_idx    <= '0;
            r_signal <= '0;
            r_coeff  <= '0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_func   <= w_func_nxt;
            r_idx    <= w_idx_nxt;
            r_signal <= w_signal_nxt;
            r_coeff  <= w_coeff_nxt;
            r_last   <= w_last_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_func_nxt   = r_func;
        w_idx_nxt    = r_idx;
        w_signal_nxt = r_signal;
        w_coeff_nxt  = r_coeff;
        w_last_nxt   = r_last;
        w_done_nxt   = 1'b0;
        w_fire_in    = bus.in_valid_i && (r_state == S_IDLE);
        w_fire_out   = bus.out_ready_i && (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (w_fire_in) begin
                    w_state_nxt  = S_STREAM;
                    w_func_nxt   = bus.func_sel_i;
                    w_idx_nxt    = '0;
                    w_signal_nxt = bus.x_i;
                    w_coeff_nxt  = rom(bus.func_sel_i, '0);
                    w_last_nxt   = 1'b0;
                end
            end
            S_STREAM: begin
                if (w_fire_out) begin
                    if (r_idx == LAST_I) begin
                        w_state_nxt  = S_TERM;
                        w_signal_nxt = NAN_W;
                        w_coeff_nxt  = NAN_W;
                        w_last_nxt   = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + ONE_I;
                        w_coeff_nxt = rom(r_func, r_idx + ONE_I);
                    end
                end
            end
            S_TERM: begin
                if (w_fire_out) begin
                    w_state_nxt  = S_IDLE;
                    w_signal_nxt = '0;
                    w_coeff_nxt  = '0;
                    w_last_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready_o  = rstn_i && (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state != S_IDLE);
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.signal_o    = r_signal;
    assign bus.coeff_o     = r_coeff;
    assign bus.last_o      = r_last;
    assign bus.done_o      = r_done;
endmodule

// File: tb/tb_coeff_sequencer.sv
// Directed bench for coeff_sequencer: reset, both ROM series,
// stalls, back-to-back requests and mid-sequence reset.
module tb_coeff_sequencer;
    logic clk = 1'b0;
    logic rstn = 1'b0;

    coeff_sequencer_if #(.DATA_WIDTH(32)) bus ();

    coeff_sequencer #(
        .DATA_WIDTH(32),
        .ADDR_LINES(4),
        .N_COEFF(10)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NAN_V = 32'h7F900000;

    logic [31:0] selu_c [10] = '{
        32'h3493F27D, 32'h3638EF1D, 32'h37D00D01, 32'h39500D01,
        32'h3AB60B61, 32'h3C088889, 32'h3D2AAAAB, 32'h3E2AAAAB,
        32'h3F000000, 32'h3F800000
    };
    logic [31:0] tanh_c [10] = '{
        32'hA317A4DB, 32'hA74A963B, 32'hAB573F9F, 32'hAF309231,
        32'hB2D7322B, 32'hB638EF1D, 32'hB9500D01, 32'hBC088889,
        32'hBE2AAAAB, 32'hBF800000
    };

    int n_tests = 0;
    int n_fail  = 0;

    // {out_valid, last, done, busy, signal, coeff}
    function automatic logic [67:0] snap();
        return {bus.out_valid_o, bus.last_o, bus.done_o, bus.busy_o,
                bus.signal_o, bus.coeff_o};
    endfunction

    task automatic test_reset();
        logic [67:0] exp_v;
        rstn = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.x_i         = 32'h12345678;
        bus.func_sel_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        exp_v = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL reset_outs c%0d: got %h want %h", c, snap(), exp_v);
            end
            n_tests++;
            if (bus.in_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_in_ready c%0d: got %b want 0", c, bus.in_ready_o);
            end
        end
        bus.in_valid_i = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.busy_o, bus.out_valid_o, bus.in_ready_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_release: got busy/valid/rdy %b%b%b want 001",
                     bus.busy_o, bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic test_selu();
        logic [31:0] x;
        logic [67:0] exp_v;
        x = 32'hBDFCD6E9;
        bus.x_i = x;
        bus.func_sel_i = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        n_tests++;
        if (bus.in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL selu_ready: got %b want 1", bus.in_ready_o);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_v = {4'b1001, x, selu_c[i]};
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL selu_beat%0d: got %h want %h", i, snap(), exp_v);
            end
            @(negedge clk);
        end
        exp_v = {4'b1101, NAN_V, NAN_V};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL selu_term: got %h want %h", snap(), exp_v);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.done_o, bus.in_ready_o, bus.busy_o, bus.out_valid_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL selu_done: got done/rdy/busy/valid %b%b%b%b want 1100",
                     bus.done_o, bus.in_ready_o, bus.busy_o, bus.out_valid_o);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL selu_done_pulse: got %b want 0", bus.done_o);
        end
    endtask

    task automatic test_tanh();
        logic [31:0] x;
        logic [67:0] exp_v;
        x = 32'h3E6C29BC;
        bus.x_i = x;
        bus.func_sel_i = 1'b1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.x_i = 32'h0;
        bus.func_sel_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_v = {4'b1001, x, tanh_c[i]};
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL tanh_beat%0d: got %h want %h", i, snap(), exp_v);
            end
            @(negedge clk);
        end
        exp_v = {4'b1101, NAN_V, NAN_V};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL tanh_term: got %h want %h", snap(), exp_v);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tanh_done: got %b want 1", bus.done_o);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x;
        logic [67:0] exp_v;
        int cyc;
        x = 32'h40490FDB;
        cyc = 0;
        bus.x_i = x;
        bus.func_sel_i = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        cyc++;
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_v = {4'b1001, x, selu_c[i]};
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h want %h", i, snap(), exp_v);
            end
            if (i == 4) begin
                bus.out_ready_i = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    cyc++;
                    n_tests++;
                    if (snap() !== exp_v) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d: got %h want %h", s, snap(), exp_v);
                    end
                end
                bus.out_ready_i = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        exp_v = {4'b1101, NAN_V, NAN_V};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL bp_term: got %h want %h", snap(), exp_v);
        end
        bus.out_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            cyc++;
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL bp_term_hold%0d: got %h want %h", s, snap(), exp_v);
            end
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        cyc++;
        n_tests++;
        if (bus.done_o !== 1'b1 || cyc !== 18) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b at cycle %0d want done=1 at 18",
                     bus.done_o, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa, xb;
        logic [67:0] exp_v;
        xa = 32'h3F000000;
        xb = 32'hC0000000;
        bus.out_ready_i = 1'b1;
        bus.x_i = xa;
        bus.func_sel_i = 1'b0;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.x_i = xb;
        bus.func_sel_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_v = {4'b1001, xa, selu_c[i]};
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_a_beat%0d: got %h want %h", i, snap(), exp_v);
            end
            @(negedge clk);
        end
        exp_v = {4'b1101, NAN_V, NAN_V};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_a_term: got %h want %h", snap(), exp_v);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.done_o, bus.in_ready_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_done_ready: got %b%b want 11",
                     bus.done_o, bus.in_ready_o);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_v = {4'b1001, xb, tanh_c[i]};
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_b_beat%0d: got %h want %h", i, snap(), exp_v);
            end
            @(negedge clk);
        end
        exp_v = {4'b1101, NAN_V, NAN_V};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_b_term: got %h want %h", snap(), exp_v);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_b_done: got %b want 1", bus.done_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] x;
        logic [67:0] exp_v;
        x = 32'h3DCCCCCD;
        bus.out_ready_i = 1'b1;
        bus.x_i = x;
        bus.func_sel_i = 1'b0;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        exp_v = {4'b1001, x, selu_c[6]};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_beat6: got %h want %h", snap(), exp_v);
        end
        rstn = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({snap(), bus.in_ready_o} !== 69'd0) begin
            n_fail++;
            $display("FAIL rmid_cleared: got %h/%b want 0/0", snap(), bus.in_ready_o);
        end
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.done_o, bus.out_valid_o, bus.last_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL rmid_quiet%0d: got done/valid/last %b%b%b want 000",
                         c, bus.done_o, bus.out_valid_o, bus.last_o);
            end
        end
        bus.x_i = x;
        bus.func_sel_i = 1'b1;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        exp_v = {4'b1001, x, tanh_c[0]};
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_restart: got %h want %h", snap(), exp_v);
        end
        repeat (11) @(negedge clk);
        n_tests++;
        if (bus.done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_restart_done: got %b want 1", bus.done_o);
        end
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.x_i         = '0;
        bus.func_sel_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_selu();
        test_tanh();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
